multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- Moore-style main control FSM for the multi-cycle RV32I datapath.
- Sequences fetch, decode, execute, memory and writeback over a single shared ALU and a unified instruction/data memory.
- Drives the 3-bit ALU_Op into the ALU control decoder, plus datapath mux selects and write enables.
- Handles memory wait states and traps on illegal opcodes and memory timeouts.

Parameters:
MEM_TIMEOUT, 16, max cycles waiting on mem_ready_i in any memory state before trapping; 0 disables the timeout.
TMO_W, 5, width of the timeout counter; must hold MEM_TIMEOUT.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
opcode_i  input  7  IR[6:0], held stable by the IR outside FETCH.
branch_cond_i  input  1  ALU branch flag: 1 = BEQ/BNE condition met.
mem_ready_i  input  1  memory completes the current read/write this cycle.
alu_op_o  output  3  to ALU control: 000 R, 001 I-arith, 010 LUI, 011 forced ADD (decodes to default add), 101 branch, 111 JALR.
alu_src_a_o  output  2  00 PC, 01 oldPC, 10 regA.
alu_src_b_o  output  2  00 regB, 01 imm, 10 const 4.
result_src_o  output  2  00 ALUOut, 01 memory data, 10 ALU result.
adr_src_o  output  1  memory address: 0 PC, 1 ALUOut.
mem_read_o  output  1  memory read request.
mem_write_o  output  1  memory write request.
ir_write_o  output  1  load IR and oldPC.
pc_write_o  output  1  load PC from result bus.
reg_write_o  output  1  register file write of rd.
trap_o  output  1  sticky error flag.
state_o  output  4  current state encoding, for debug.

Behaviour:
- State encodings: RST=0, FETCH=1, DECODE=2, MEM_ADR=3, MEM_READ=4, MEM_WB=5, MEM_WRITE=6, EXEC_R=7, EXEC_I=8, LUI=9, ALU_WB=10, BRANCH=11, JALR=12, JAL=13, TRAP=14.
- Reset forces RST. In RST all outputs are 0, state_o=0, and the timeout counter is 0. RST goes to FETCH unconditionally on the next edge.
- Outputs not listed for a state are 0.
- FETCH: adr_src=0, mem_read=1, src_a=00, src_b=10, alu_op=011. ir_write and pc_write equal mem_ready_i (the only Mealy outputs). Stay in FETCH until mem_ready_i, then go to DECODE.
- DECODE: src_a=01, src_b=01, alu_op=011, so ALUOut=oldPC+imm. Next state by opcode:
  - 0000011 or 0100011 -> MEM_ADR
  - 0110011 -> EXEC_R
  - 0010011 -> EXEC_I
  - 0110111 -> LUI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - 1100111 -> JALR
  - any other -> TRAP
- MEM_ADR: src_a=10, src_b=01, alu_op=011. Go to MEM_READ if the opcode is a load, else MEM_WRITE.
- MEM_READ: adr_src=1, mem_read=1. Wait for mem_ready_i, then go to MEM_WB.
- MEM_WB: result_src=01, reg_write=1. Go to FETCH.
- MEM_WRITE: adr_src=1, mem_write=1. Wait for mem_ready_i, then go to FETCH.
- EXEC_R: src_a=10, src_b=00, alu_op=000. Go to ALU_WB.
- EXEC_I: src_a=10, src_b=01, alu_op=001. Go to ALU_WB.
- LUI: src_b=01, alu_op=010. Go to ALU_WB.
- ALU_WB: result_src=00, reg_write=1. Go to FETCH.
- BRANCH: src_a=10, src_b=00, alu_op=101, result_src=00, pc_write=branch_cond_i. Go to FETCH.
- JALR: src_a=10, src_b=01, alu_op=111, so ALUOut=rs1+imm. Go to JAL.
- JAL: src_a=01, src_b=10, alu_op=011, result_src=00, pc_write=1, so PC<=ALUOut and ALUOut<=oldPC+4. Go to ALU_WB.
- Timeout counter:
  - Cleared on every state change.
  - Increments each cycle spent in FETCH, MEM_READ or MEM_WRITE while mem_ready_i=0.
  - When it reaches MEM_TIMEOUT with mem_ready_i still 0, go to TRAP.
  - If mem_ready_i is 1 in the cycle the count hits MEM_TIMEOUT, ready wins and there is no trap.
- TRAP: trap_o=1, all write enables and requests 0. TRAP is absorbing; only reset leaves it.
- Reset asserted mid-instruction (including mid memory wait) aborts immediately to RST. No partial writes are issued after assertion.
- state_o always reflects the registered state.

Optional Feature:
MCU_PERF_CNT_EN
- Defined:
  - Adds 32-bit outputs cycle_cnt_o and instret_o, both reset to 0.
  - cycle_cnt_o increments every cycle outside RST and TRAP.
  - instret_o increments on each transition into FETCH from MEM_WB, MEM_WRITE, ALU_WB or BRANCH.
  - Both counters wrap at 2^32-1 -> 0.
- Undefined: the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then R-type opcode 0110011, mem_ready_i=1 -> states 0,1,2,7,10,1. alu_op 011 in FETCH, 000 in EXEC_R. reg_write_o=1 only in ALU_WB.
- LW 0000011 with mem_ready_i low 3 cycles in MEM_READ -> stays in state 4 for 3 cycles, then 5. result_src_o=01 and reg_write_o=1 for exactly 1 cycle. instret_o +1 when enabled.
- BEQ 1100011: branch_cond_i=1 -> pc_write_o=1 in BRANCH with alu_op_o=101. Repeat with branch_cond_i=0 -> pc_write_o=0. Both return to FETCH.
- JALR 1100111 -> sequence 2,12,13,10. pc_write_o=1 only in JAL and the FETCH ready cycle. alu_op_o=111 in JALR.
- Illegal opcode 1111111 -> TRAP (14), trap_o=1 stays high for 20 cycles with no writes. Reset returns to RST then FETCH.
- MEM_TIMEOUT=16, SW with mem_ready_i held 0 -> TRAP after 16 wait cycles in MEM_WRITE. Repeat with ready on cycle 16 -> FETCH, no trap.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multi-cycle RV32I datapath: sequences fetch, decode,
// execute, memory and writeback over one shared ALU and a unified memory.
// Memory waits are bounded by MEM_TIMEOUT (0 disables); illegal opcodes trap.
// Optional build macro MCU_PERF_CNT_EN adds cycle_cnt_o / instret_o counters.
module multicycle_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned TMO_W       = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode_i,
  input  logic       branch_cond_i,
  input  logic       mem_ready_i,
  output logic [2:0] alu_op_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic       adr_src_o,
  output logic       mem_read_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       trap_o,
  output logic [3:0] state_o
`ifdef MCU_PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instret_o
`endif
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  typedef enum logic [3:0] {
    S_RST       = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_MEM_ADR   = 4'd3,
    S_MEM_READ  = 4'd4,
    S_MEM_WB    = 4'd5,
    S_MEM_WRITE = 4'd6,
    S_EXEC_R    = 4'd7,
    S_EXEC_I    = 4'd8,
    S_LUI       = 4'd9,
    S_ALU_WB    = 4'd10,
    S_BRANCH    = 4'd11,
    S_JALR      = 4'd12,
    S_JAL       = 4'd13,
    S_TRAP      = 4'd14
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [TMO_W-1:0]   tmo;
  logic [TMO_W-1:0]   tmo_nxt;
  logic               mem_wait;
  logic               tmo_hit;

  // Wait-state detection and memory timeout condition
  always_comb begin
    mem_wait = (state == S_FETCH) || (state == S_MEM_READ) || (state == S_MEM_WRITE);
    tmo_hit  = (MEM_TIMEOUT != 32'd0) && mem_wait && !mem_ready_i &&
               (tmo == TMO_W'(MEM_TIMEOUT));
  end

  // Next-state selection; memory ready takes priority over the timeout
  always_comb begin
    state_nxt = state;
    case (state)
      S_RST:       state_nxt = S_FETCH;
      S_FETCH:     if (mem_ready_i) state_nxt = S_DECODE;
                   else if (tmo_hit) state_nxt = S_TRAP;
      S_DECODE: begin
        case (opcode_i)
          OP_LOAD, OP_STORE: state_nxt = S_MEM_ADR;
          OP_R:              state_nxt = S_EXEC_R;
          OP_I:              state_nxt = S_EXEC_I;
          OP_LUI:            state_nxt = S_LUI;
          OP_BR:             state_nxt = S_BRANCH;
          OP_JAL:            state_nxt = S_JAL;
          OP_JALR:           state_nxt = S_JALR;
          default:           state_nxt = S_TRAP;
        endcase
      end
      S_MEM_ADR:   state_nxt = (opcode_i == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready_i) state_nxt = S_MEM_WB;
                   else if (tmo_hit) state_nxt = S_TRAP;
      S_MEM_WB:    state_nxt = S_FETCH;
      S_MEM_WRITE: if (mem_ready_i) state_nxt = S_FETCH;
                   else if (tmo_hit) state_nxt = S_TRAP;
      S_EXEC_R:    state_nxt = S_ALU_WB;
      S_EXEC_I:    state_nxt = S_ALU_WB;
      S_LUI:       state_nxt = S_ALU_WB;
      S_ALU_WB:    state_nxt = S_FETCH;
      S_BRANCH:    state_nxt = S_FETCH;
      S_JALR:      state_nxt = S_JAL;
      S_JAL:       state_nxt = S_ALU_WB;
      S_TRAP:      state_nxt = S_TRAP;
      default:     state_nxt = S_TRAP;
    endcase
  end

  // Timeout counter: cleared on any state change, counts unanswered wait cycles
  always_comb begin
    tmo_nxt = tmo;
    if (state_nxt != state) begin
      tmo_nxt = '0;
    end else if (mem_wait && !mem_ready_i && (MEM_TIMEOUT != 32'd0)) begin
      tmo_nxt = tmo + TMO_W'(1);
    end
  end

  // State, timeout counter and Moore outputs registered from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= S_RST;
      tmo          <= '0;
      alu_op_o     <= 3'b000;
      alu_src_a_o  <= 2'b00;
      alu_src_b_o  <= 2'b00;
      result_src_o <= 2'b00;
      adr_src_o    <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      reg_write_o  <= 1'b0;
      trap_o       <= 1'b0;
    end else begin
      state        <= state_nxt;
      tmo          <= tmo_nxt;
      alu_op_o     <= 3'b000;
      alu_src_a_o  <= 2'b00;
      alu_src_b_o  <= 2'b00;
      result_src_o <= 2'b00;
      adr_src_o    <= 1'b0;
      mem_read_o   <= 1'b0;
      mem_write_o  <= 1'b0;
      reg_write_o  <= 1'b0;
      trap_o       <= 1'b0;
      case (state_nxt)
        S_FETCH: begin
          mem_read_o  <= 1'b1;
          alu_src_b_o <= 2'b10;
          alu_op_o    <= 3'b011;
        end
        S_DECODE: begin
          alu_src_a_o <= 2'b01;
          alu_src_b_o <= 2'b01;
          alu_op_o    <= 3'b011;
        end
        S_MEM_ADR: begin
          alu_src_a_o <= 2'b10;
          alu_src_b_o <= 2'b01;
          alu_op_o    <= 3'b011;
        end
        S_MEM_READ: begin
          adr_src_o  <= 1'b1;
          mem_read_o <= 1'b1;
        end
        S_MEM_WB: begin
          result_src_o <= 2'b01;
          reg_write_o  <= 1'b1;
        end
        S_MEM_WRITE: begin
          adr_src_o   <= 1'b1;
          mem_write_o <= 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a_o <= 2'b10;
          alu_op_o    <= 3'b000;
        end
        S_EXEC_I: begin
          alu_src_a_o <= 2'b10;
          alu_src_b_o <= 2'b01;
          alu_op_o    <= 3'b001;
        end
        S_LUI: begin
          alu_src_b_o <= 2'b01;
          alu_op_o    <= 3'b010;
        end
        S_ALU_WB: begin
          reg_write_o <= 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o <= 2'b10;
          alu_op_o    <= 3'b101;
        end
        S_JALR: begin
          alu_src_a_o <= 2'b10;
          alu_src_b_o <= 2'b01;
          alu_op_o    <= 3'b111;
        end
        S_JAL: begin
          alu_src_a_o <= 2'b01;
          alu_src_b_o <= 2'b10;
          alu_op_o    <= 3'b011;
        end
        S_TRAP: begin
          trap_o <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // Input-dependent enables: IR/PC load on fetch completion, PC load in JAL and taken branch
  assign ir_write_o = (state == S_FETCH) && mem_ready_i;
  assign pc_write_o = ((state == S_FETCH) && mem_ready_i) ||
                      (state == S_JAL) ||
                      ((state == S_BRANCH) && branch_cond_i);
  assign state_o    = state;

`ifdef MCU_PERF_CNT_EN
  // Cycle and retired-instruction counters, wrapping at 2^32
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle_cnt_o <= 32'd0;
      instret_o   <= 32'd0;
    end else begin
      if ((state != S_RST) && (state != S_TRAP)) begin
        cycle_cnt_o <= cycle_cnt_o + 32'd1;
      end
      if ((state_nxt == S_FETCH) &&
          ((state == S_MEM_WB) || (state == S_MEM_WRITE) ||
           (state == S_ALU_WB) || (state == S_BRANCH))) begin
        instret_o <= instret_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded
// into its expected per-cycle state path from the opcode and memory delays.
module tb_multicycle_control_unit;

  localparam int unsigned TMO = 16;

  localparam int ST_RST = 0, ST_FETCH = 1, ST_DECODE = 2, ST_MEM_ADR = 3,
                 ST_MEM_READ = 4, ST_MEM_WB = 5, ST_MEM_WRITE = 6, ST_EXEC_R = 7,
                 ST_EXEC_I = 8, ST_LUI = 9, ST_ALU_WB = 10, ST_BRANCH = 11,
                 ST_JALR = 12, ST_JAL = 13, ST_TRAP = 14;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] opcode_i = 7'd0;
  logic       branch_cond_i = 1'b0;
  logic       mem_ready_i = 1'b0;
  logic [2:0] alu_op_o;
  logic [1:0] alu_src_a_o, alu_src_b_o, result_src_o;
  logic       adr_src_o, mem_read_o, mem_write_o, ir_write_o, pc_write_o, reg_write_o, trap_o;
  logic [3:0] state_o;
`ifdef MCU_PERF_CNT_EN
  logic [31:0] cycle_cnt_o, instret_o;
`endif

  multicycle_control_unit #(.MEM_TIMEOUT(TMO), .TMO_W(5)) dut (
    .clk(clk), .reset(reset), .opcode_i(opcode_i), .branch_cond_i(branch_cond_i),
    .mem_ready_i(mem_ready_i), .alu_op_o(alu_op_o), .alu_src_a_o(alu_src_a_o),
    .alu_src_b_o(alu_src_b_o), .result_src_o(result_src_o), .adr_src_o(adr_src_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .pc_write_o(pc_write_o), .reg_write_o(reg_write_o), .trap_o(trap_o),
    .state_o(state_o)
`ifdef MCU_PERF_CNT_EN
    , .cycle_cnt_o(cycle_cnt_o), .instret_o(instret_o)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] st;
    logic       rdy;
  } step_t;

  step_t       plan[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] model_cyc = 32'd0;
  logic [31:0] model_ret = 32'd0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [15:0] dut_outs();
    return {alu_op_o, alu_src_a_o, alu_src_b_o, result_src_o, adr_src_o, mem_read_o,
            mem_write_o, ir_write_o, pc_write_o, reg_write_o, trap_o};
  endfunction

  // Control outputs each state must present, straight from the state table
  function automatic logic [15:0] exp_outs(input int st, input bit rdy, input bit cond);
    logic [2:0] aop = 3'b000;
    logic [1:0] sa = 2'b00, sb = 2'b00, rs = 2'b00;
    logic adr = 0, mr = 0, mw = 0, irw = 0, pcw = 0, rw = 0, tr = 0;
    case (st)
      ST_FETCH:     begin mr = 1; sb = 2'b10; aop = 3'b011; irw = rdy; pcw = rdy; end
      ST_DECODE:    begin sa = 2'b01; sb = 2'b01; aop = 3'b011; end
      ST_MEM_ADR:   begin sa = 2'b10; sb = 2'b01; aop = 3'b011; end
      ST_MEM_READ:  begin adr = 1; mr = 1; end
      ST_MEM_WB:    begin rs = 2'b01; rw = 1; end
      ST_MEM_WRITE: begin adr = 1; mw = 1; end
      ST_EXEC_R:    begin sa = 2'b10; sb = 2'b00; aop = 3'b000; end
      ST_EXEC_I:    begin sa = 2'b10; sb = 2'b01; aop = 3'b001; end
      ST_LUI:       begin sb = 2'b01; aop = 3'b010; end
      ST_ALU_WB:    begin rw = 1; end
      ST_BRANCH:    begin sa = 2'b10; aop = 3'b101; pcw = cond; end
      ST_JALR:      begin sa = 2'b10; sb = 2'b01; aop = 3'b111; end
      ST_JAL:       begin sa = 2'b01; sb = 2'b10; aop = 3'b011; pcw = 1; end
      ST_TRAP:      begin tr = 1; end
      default:      begin end
    endcase
    return {aop, sa, sb, rs, adr, mr, mw, irw, pcw, rw, tr};
  endfunction

  function automatic bit is_legal(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) || (op == OP_I) ||
           (op == OP_LUI) || (op == OP_BR) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

  task automatic push(input int st, input bit rdy);
    step_t s;
    s.st  = 4'(st);
    s.rdy = rdy;
    plan.push_back(s);
  endtask

  // Memory answers after w idle cycles; more than TMO idle cycles means a trap
  task automatic add_wait(input int st, input int w, output bit trapped);
    if (w > int'(TMO)) begin
      for (int i = 0; i <= int'(TMO); i++) push(st, 1'b0);
      trapped = 1'b1;
    end else begin
      for (int i = 0; i < w; i++) push(st, 1'b0);
      push(st, 1'b1);
      trapped = 1'b0;
    end
  endtask

  // Expected state path of one instruction; ends in TRAP entries if it traps
  task automatic build_plan(input logic [6:0] op, input int fw, input int mw,
                            input int trap_len, output bit trapped);
    bit tr;
    plan.delete();
    add_wait(ST_FETCH, fw, tr);
    if (!tr) begin
      push(ST_DECODE, 1'($urandom));
      case (op)
        OP_LOAD:  begin push(ST_MEM_ADR, 1'($urandom)); add_wait(ST_MEM_READ, mw, tr);
                        if (!tr) push(ST_MEM_WB, 1'($urandom)); end
        OP_STORE: begin push(ST_MEM_ADR, 1'($urandom)); add_wait(ST_MEM_WRITE, mw, tr); end
        OP_R:     begin push(ST_EXEC_R, 1'($urandom)); push(ST_ALU_WB, 1'($urandom)); end
        OP_I:     begin push(ST_EXEC_I, 1'($urandom)); push(ST_ALU_WB, 1'($urandom)); end
        OP_LUI:   begin push(ST_LUI, 1'($urandom)); push(ST_ALU_WB, 1'($urandom)); end
        OP_BR:    push(ST_BRANCH, 1'($urandom));
        OP_JAL:   begin push(ST_JAL, 1'($urandom)); push(ST_ALU_WB, 1'($urandom)); end
        OP_JALR:  begin push(ST_JALR, 1'($urandom)); push(ST_JAL, 1'($urandom));
                        push(ST_ALU_WB, 1'($urandom)); end
        default:  tr = 1'b1;
      endcase
    end
    if (tr) for (int i = 0; i < trap_len; i++) push(ST_TRAP, 1'($urandom));
    trapped = tr;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    mem_ready_i = 1'($urandom);
    opcode_i = 7'($urandom);
    #1;
    check("rst_state", 32'(state_o), 32'(ST_RST));
    check("rst_ctrl", 32'(dut_outs()), 32'd0);
    model_cyc = 32'd0;
    model_ret = 32'd0;
`ifdef MCU_PERF_CNT_EN
    check("rst_cycle_cnt", cycle_cnt_o, 32'd0);
    check("rst_instret", instret_o, 32'd0);
`endif
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_hold_state", 32'(state_o), 32'(ST_RST));
  endtask

  // Drive the plan cycle by cycle and compare state and controls mid-cycle
  task automatic exec_plan(input logic [6:0] op, input bit cond, input int abort_at,
                           output bit aborted);
    aborted = 1'b0;
    for (int i = 0; i < plan.size(); i++) begin
      @(negedge clk);
      opcode_i = op;
      branch_cond_i = cond;
      mem_ready_i = plan[i].rdy;
      #1;
      check("state", 32'(state_o), 32'(plan[i].st));
      check("ctrl", 32'(dut_outs()), 32'(exp_outs(int'(plan[i].st), plan[i].rdy, cond)));
`ifdef MCU_PERF_CNT_EN
      check("cycle_cnt", cycle_cnt_o, model_cyc);
      check("instret", instret_o, model_ret);
`endif
      if (int'(plan[i].st) != ST_RST && int'(plan[i].st) != ST_TRAP) model_cyc++;
      if (int'(plan[i].st) == ST_MEM_WB || int'(plan[i].st) == ST_ALU_WB ||
          int'(plan[i].st) == ST_BRANCH ||
          (int'(plan[i].st) == ST_MEM_WRITE && plan[i].rdy)) model_ret++;
      if (i == abort_at) begin
        #2;
        reset = 1'b1;
        #1;
        check("abort_state", 32'(state_o), 32'(ST_RST));
        check("abort_ctrl", 32'(dut_outs()), 32'd0);
        aborted = 1'b1;
        break;
      end
    end
  endtask

  task automatic run_instr(input logic [6:0] op, input int fw, input int mw,
                           input bit cond, input int trap_len, input int abort_at);
    bit tr, ab;
    build_plan(op, fw, mw, trap_len, tr);
    exec_plan(op, cond, abort_at, ab);
    if (tr || ab) do_reset();
  endtask

  initial begin
    logic [6:0] ops[8];
    logic [6:0] op;
    int fw, mw, ab;
    ops = '{OP_LOAD, OP_STORE, OP_R, OP_I, OP_LUI, OP_BR, OP_JAL, OP_JALR};

    do_reset();
    run_instr(OP_R, 0, 0, 1'b0, 4, -1);
    run_instr(OP_LOAD, 0, 3, 1'b0, 4, -1);
    run_instr(OP_BR, 0, 0, 1'b1, 4, -1);
    run_instr(OP_BR, 2, 0, 1'b0, 4, -1);
    run_instr(OP_JALR, 1, 0, 1'b0, 4, -1);
    run_instr(7'b1111111, 0, 0, 1'b0, 20, -1);
    run_instr(OP_STORE, 0, 17, 1'b0, 4, -1);
    run_instr(OP_STORE, 0, 16, 1'b0, 4, -1);
    run_instr(OP_LOAD, 16, 16, 1'b1, 4, -1);
    run_instr(OP_I, 17, 0, 1'b0, 4, -1);
    run_instr(OP_LOAD, 0, 10, 1'b0, 4, 5);
    run_instr(OP_LUI, 0, 0, 1'b0, 4, -1);
    run_instr(OP_JAL, 0, 0, 1'b0, 4, -1);

    for (int n = 0; n < 200; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do op = 7'($urandom); while (is_legal(op));
      end else begin
        op = ops[$urandom_range(0, 7)];
      end
      fw = ($urandom_range(0, 9) < 8) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 18));
      mw = ($urandom_range(0, 9) < 7) ? int'($urandom_range(0, 3)) : int'($urandom_range(14, 18));
      ab = ($urandom_range(0, 29) == 0) ? int'($urandom_range(0, 4)) : -1;
      run_instr(op, fw, mw, 1'($urandom), 3, ab);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
